// File: rtl/jtframe_rom_pkg.sv
// rtl/jtframe_rom_pkg.sv - shared constants, FSM states and grant helper for the ROM arbiter
package jtframe_rom_pkg;

  localparam int SDRAM_AW = 22;
  localparam int LINE_W   = 32;
  localparam int WORD_W   = 16;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  // rr=1: first request at or above ptr, wrapping at slots; rr=0: lowest index wins
  function automatic logic [3:0] next_grant(input logic [15:0] req, input logic [3:0] ptr,
                                            input int slots, input logic rr);
    logic [3:0] g;
    logic       found;
    int         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = rr ? int'(ptr) + k : k;
      if (idx >= slots) idx = idx - slots;
      if (k < slots && !found && req[idx[3:0]]) begin
        g     = idx[3:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/jtframe_rom_line.sv
// rtl/jtframe_rom_line.sv - one slot's 32-bit cache line with tag/valid, hit compare and word select
module jtframe_rom_line
  import jtframe_rom_pkg::*;
#(
  parameter int SLOT_AW = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               fill_i,
  input  logic [SLOT_AW-2:0] fill_tag_i,
  input  logic [LINE_W-1:0]  fill_data_i,
  input  logic [SLOT_AW-1:0] addr_i,
  output logic               hit_o,
  output logic [WORD_W-1:0]  dout_o
);

  logic               valid_q;
  logic [SLOT_AW-2:0] tag_q;
  logic [LINE_W-1:0]  line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      line_q  <= fill_data_i;
    end
  end

  assign hit_o  = valid_q & (tag_q == addr_i[SLOT_AW-1:1]);
  assign dout_o = addr_i[0] ? line_q[LINE_W-1:WORD_W] : line_q[WORD_W-1:0];

endmodule

// File: rtl/jtframe_rom_arb.sv
// rtl/jtframe_rom_arb.sv - N-slot cached SDRAM read arbiter; JTFRAME_ROM_STATS_EN adds miss counters
module jtframe_rom_arb
  import jtframe_rom_pkg::*;
#(
  parameter int                  SLOTS   = 4,
  parameter int                  SLOT_AW = 18,
  parameter logic [SLOTS*22-1:0] OFFSETS = {SLOTS{22'h0}},
  parameter int                  RR_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       downloading,
  input  logic [SLOTS-1:0]           slot_cs,
  input  logic [SLOTS*SLOT_AW-1:0]   slot_addr,
  output logic [SLOTS*WORD_W-1:0]    slot_dout,
  output logic [SLOTS-1:0]           slot_ok,
  output logic                       sdram_req,
  output logic [SDRAM_AW-1:0]        sdram_addr,
  input  logic                       sdram_ack,
  input  logic                       data_rdy,
  input  logic [LINE_W-1:0]          data_read,
  output logic                       refresh_en
`ifdef JTFRAME_ROM_STATS_EN
  ,
  output logic [SLOTS*16-1:0]        miss_cnt
`endif
);

  logic [1:0]          state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [SLOT_AW-2:0]  tag_q, tag_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                refresh_q, refresh_d;

  logic [SLOTS-1:0]    hit, miss, fill;
  logic [3:0]          g;
  logic [SLOT_AW-2:0]  g_tag;
  logic [SDRAM_AW-1:0] g_off;
  logic                any_miss;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtframe_rom_line #(.SLOT_AW(SLOT_AW)) u_line (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (downloading),
      .fill_i      (fill[i]),
      .fill_tag_i  (tag_q),
      .fill_data_i (data_read),
      .addr_i      (slot_addr[i*SLOT_AW +: SLOT_AW]),
      .hit_o       (hit[i]),
      .dout_o      (slot_dout[i*WORD_W +: WORD_W])
    );
    assign slot_ok[i] = slot_cs[i] & hit[i];
    assign miss[i]    = slot_cs[i] & ~hit[i] & ~downloading;
    // fill goes to the latched grant with the latched tag, whatever the live address is now
    assign fill[i]    = (state_q == WAIT_DATA) & data_rdy & ~downloading & (grant_q == 4'(i));
  end

  assign any_miss = |miss;
  assign g        = next_grant(16'(miss), ptr_q, SLOTS, RR_EN != 0);

  always_comb begin
    g_tag = '0;
    g_off = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (g == 4'(i)) begin
        g_tag = slot_addr[i*SLOT_AW+1 +: SLOT_AW-1];
        g_off = OFFSETS[i*SDRAM_AW +: SDRAM_AW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tag_d     = tag_q;
    req_d     = req_q;
    addr_d    = addr_q;
    refresh_d = refresh_q;
    if (downloading) begin
      state_d   = IDLE;
      req_d     = 1'b0;
      refresh_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_miss) begin
            grant_d   = g;
            tag_d     = g_tag;
            addr_d    = g_off + SDRAM_AW'({g_tag, 1'b0});
            req_d     = 1'b1;
            refresh_d = 1'b0;
            ptr_d     = (g == 4'(SLOTS-1)) ? 4'd0 : g + 4'd1;
            state_d   = WAIT_ACK;
          end else begin
            refresh_d = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_rdy) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      tag_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      refresh_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      refresh_q <= refresh_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;

`ifdef JTFRAME_ROM_STATS_EN
  logic                dl_q;
  logic [SLOTS*16-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      dl_q <= downloading;
      for (int i = 0; i < SLOTS; i++) begin
        if (downloading && !dl_q) begin
          cnt_q[i*16 +: 16] <= '0;
        end else if (state_q == IDLE && !downloading && any_miss && g == 4'(i)
                     && cnt_q[i*16 +: 16] != 16'hFFFF) begin
          cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign miss_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb/tb_jtframe_rom_arb.sv - randomized bench for jtframe_rom_arb, round-robin and fixed-priority builds
module tb_jtframe_rom_arb;

  localparam logic [4*22-1:0] OFFS = {22'h3F_FFF0, 22'h12_3400, 22'h06_0000, 22'h00_1000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [3:0]  cs = '0;
  logic [17:0] a[4];
  logic [71:0] slot_addr;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = '0;
  logic        sel = 1'b1;

  logic [63:0] dout_r, dout_f, dout;
  logic [3:0]  ok_r, ok_f, ok;
  logic        req_r, req_f, req;
  logic [21:0] addr_r, addr_f, addr;
  logic        ref_r, ref_f, refr;
`ifdef JTFRAME_ROM_STATS_EN
  logic [63:0] cnt_r, cnt_f, cnt;
  assign cnt = sel ? cnt_r : cnt_f;
`endif

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) slot_addr[i*18 +: 18] = a[i];
  end

  assign dout = sel ? dout_r : dout_f;
  assign ok   = sel ? ok_r   : ok_f;
  assign req  = sel ? req_r  : req_f;
  assign addr = sel ? addr_r : addr_f;
  assign refr = sel ? ref_r  : ref_f;

  jtframe_rom_arb #(.SLOTS(4), .SLOT_AW(18), .OFFSETS(OFFS), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr(slot_addr),
    .slot_dout(dout_r), .slot_ok(ok_r), .sdram_req(req_r), .sdram_addr(addr_r),
    .sdram_ack(sdram_ack & sel), .data_rdy(data_rdy & sel), .data_read(data_read),
    .refresh_en(ref_r)
`ifdef JTFRAME_ROM_STATS_EN
    , .miss_cnt(cnt_r)
`endif
  );

  jtframe_rom_arb #(.SLOTS(4), .SLOT_AW(18), .OFFSETS(OFFS), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr(slot_addr),
    .slot_dout(dout_f), .slot_ok(ok_f), .sdram_req(req_f), .sdram_addr(addr_f),
    .sdram_ack(sdram_ack & ~sel), .data_rdy(data_rdy & ~sel), .data_read(data_read),
    .refresh_en(ref_f)
`ifdef JTFRAME_ROM_STATS_EN
    , .miss_cnt(cnt_f)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // reference model: what each slot has cached, round-robin pointer, grants per slot
  logic [21:0] off[4];
  bit          m_valid[4];
  logic [16:0] m_tag[4];
  logic [31:0] m_line[4];
  int          m_ptr;
  int          m_cnt[4];

  function automatic bit m_hit(int i);
    return m_valid[i] && (m_tag[i] == a[i][17:1]);
  endfunction

  function automatic int pick();
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = sel ? (m_ptr + k) % 4 : k;
      if (cs[idx] && !m_hit(idx)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [21:0] exp_addr(int g);
    return off[g] + 22'(a[g] & 18'h3FFFE);
  endfunction

  function automatic logic [17:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 18'h3FFF8 + 18'($urandom_range(0, 7));
    return 18'($urandom_range(0, 31));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
    end
    m_ptr = 0;
  endtask

  task automatic take(input int g);
    m_ptr = (g + 1) % 4;
    m_cnt[g]++;
  endtask

  task automatic check_outputs();
    logic exp_ok;
    for (int i = 0; i < 4; i++) begin
      exp_ok = cs[i] && m_hit(i);
      check($sformatf("slot_ok%0d", i), 32'(ok[i]), 32'(exp_ok));
      if (exp_ok)
        check($sformatf("slot_dout%0d", i), 32'(dout[i*16 +: 16]),
              32'(a[i][0] ? m_line[i][31:16] : m_line[i][15:0]));
    end
  endtask

  // called just after a rising edge with the inputs for the next cycle already driven
  task automatic run_txn(input int ack_dly, input int rdy_dly, input bit chg,
                         input logic [17:0] new_a, input logic [31:0] d);
    int g;
    logic [16:0] t;
    logic [21:0] ea;
    #1;
    check_outputs();
    g = pick();
    if (g < 0) begin
      sdram_ack = 1'b1;
      data_rdy  = 1'b1;
      @(posedge clk); #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      check("idle_req", 32'(req), 32'd0);
      check("idle_refresh", 32'(refr), 32'd1);
      check_outputs();
      return;
    end
    t  = a[g][17:1];
    ea = exp_addr(g);
    take(g);
    @(posedge clk); #1;
    data_rdy = 1'b0;
    check("req", 32'(req), 32'd1);
    check("sdram_addr", 32'(addr), 32'(ea));
    check("refresh_busy", 32'(refr), 32'd0);
    for (int k = 0; k < ack_dly; k++) begin
      data_rdy = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      data_rdy = 1'b0;
      check("req_hold", 32'(req), 32'd1);
      check("addr_hold", 32'(addr), 32'(ea));
    end
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    check("req_drop", 32'(req), 32'd0);
    check("refresh_busy2", 32'(refr), 32'd0);
    if (chg) a[g] = new_a;
    #1;
    check_outputs();
    for (int k = 0; k < rdy_dly; k++) begin
      sdram_ack = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      sdram_ack = 1'b0;
    end
    data_read = d;
    data_rdy  = 1'b1;
    @(posedge clk); #1;
    data_rdy  = 1'b0;
    m_valid[g] = 1;
    m_tag[g]   = t;
    m_line[g]  = d;
    check_outputs();
  endtask

  task automatic phase_reset();
    rst = 1'b1;
    cs = '0;
    downloading = 1'b0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    for (int i = 0; i < 4; i++) a[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_refresh", 32'(refr), 32'd1);
    check("rst_dout_lo", dout[31:0], 32'd0);
    check("rst_dout_hi", dout[63:32], 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run_phase();
    int g;
    phase_reset();

    // all four slots missing together
    cs = 4'b1111;
    for (int i = 0; i < 4; i++) a[i] = 18'h100 + 18'(i);
    run_txn(1, 1, 0, '0, $urandom);
    run_txn(0, 0, 0, '0, $urandom);
    a[0] = 18'h200;
    run_txn(2, 0, 0, '0, $urandom);
    run_txn(0, 2, 0, '0, $urandom);
    run_txn(1, 1, 0, '0, $urandom);

    // single miss on slot 1, then the neighbouring word hits without a new request
    cs = 4'b0010;
    a[1] = 18'h00005;
    run_txn(2, 1, 0, '0, 32'hBEEF_1234);
    check("single_ok", 32'(ok[1]), 32'd1);
    check("single_dout", 32'(dout[31:16]), 32'h0000_BEEF);
    a[1] = 18'h00004;
    #1;
    check("hit_ok", 32'(ok[1]), 32'd1);
    check("hit_dout", 32'(dout[31:16]), 32'h0000_1234);
    repeat (3) begin
      @(posedge clk); #1;
      check("hit_no_req", 32'(req), 32'd0);
    end

    // asynchronous reset while waiting for data
    cs = 4'b0001;
    a[0] = 18'h33;
    #1;
    g = pick();
    take(g);
    @(posedge clk); #1;
    check("rst_mid_req", 32'(req), 32'd1);
    sdram_ack = 1'b1;
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("amid_req", 32'(req), 32'd0);
    check("amid_addr", 32'(addr), 32'd0);
    check("amid_refresh", 32'(refr), 32'd1);
    check("amid_ok", 32'(ok), 32'd0);
    check("amid_dout", dout[31:16], 32'd0);
    #1;
    rst = 1'b0;
    model_clear();
    data_read = 32'hDEAD_BEEF;
    data_rdy  = 1'b1;
    run_txn(1, 1, 0, '0, 32'h0BAD_F00D);

    // address moves while the fill is in flight
    a[0] = 18'h10;
    run_txn(1, 2, 1, 18'h20, $urandom);
    check("chg_ok", 32'(ok[0]), 32'd0);
    run_txn(0, 1, 0, '0, $urandom);

    // download aborts a pending request
    cs = 4'b0101;
    a[2] = 18'h7;
    run_txn(1, 0, 0, '0, $urandom);
    cs = 4'b0111;
    a[1] = 18'h9;
    #1;
    g = pick();
    take(g);
    @(posedge clk); #1;
    check("dl_pre_req", 32'(req), 32'd1);
    downloading = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
    end
    check("dl_req", 32'(req), 32'd0);
    check("dl_refresh", 32'(refr), 32'd1);
    check("dl_ok", 32'(ok), 32'd0);
    @(posedge clk); #1;
    check("dl_ok2", 32'(ok), 32'd0);
    downloading = 1'b0;
    for (int k = 0; k < 4; k++) run_txn(1, 1, 0, '0, $urandom);

    // random traffic
    for (int it = 0; it < 150; it++) begin
      cs = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) a[i] = rnd_addr();
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
              rnd_addr(), $urandom);
    end

`ifdef JTFRAME_ROM_STATS_EN
    for (int i = 0; i < 4; i++)
      check($sformatf("miss_cnt%0d", i), 32'(cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) off[i] = OFFS[i*22 +: 22];
    sel = 1'b1;
    run_phase();
    sel = 1'b0;
    run_phase();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
